hazard_controller: RTL

Pipeline hazard and sequencing controller for the five-stage core: it decides each cycle which stages hold, which are flushed, and which operand sources the execute stage selects. It consumes the taken-redirect output of the execute-stage conditional logic, the register addresses of the D/E/M/W stages, and a memory-stage request/ready handshake. It contains a memory-wait FSM with timeout and a saturating stall-cycle counter. It sits beside the pipeline registers and drives their enable and clear inputs.

---
 rtl/hazard_controller.sv | 106 ++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: forwarding, load-use/redirect hazards and memory-wait sequencing
// for the five-stage pipeline, with timeout error and saturating stall counter.
module hazard_controller #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcEout,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);
    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t           state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             ldrstall, memstall;

    // R15 is the PC and is never produced by a later stage's result.
    function automatic logic [1:0] fwd(input logic [3:0] ra);
        return (ra != 4'hF && RegWriteM && WA3M == ra) ? 2'b10 :
               (ra != 4'hF && RegWriteW && WA3W == ra) ? 2'b01 : 2'b00;
    endfunction

    assign ldrstall = MemtoRegE & (WA3E == RA1D | WA3E == RA2D);
    assign memstall = MemReqM & ~MemReadyM & (state_q == IDLE || state_q == WAIT);

    always_comb begin
        ForwardAE  = reset ? fwd(RA1E) : 2'b00;
        ForwardBE  = reset ? fwd(RA2E) : 2'b00;
        MemErr     = reset & mem_err_q;
        StallCount = reset ? stall_cnt_q : '0;
        {StallF, StallD, StallE, StallM} = 4'b0000;
        {FlushD, FlushE, FlushW} = 3'b000;
        if (reset) begin
            if (memstall) begin
                {StallF, StallD, StallE, StallM} = 4'b1111;
                FlushW = 1'b1;
            end else if (PCSrcEout) begin
                {FlushD, FlushE} = 2'b11;
            end else if (ldrstall) begin
                {StallF, StallD, FlushE} = 3'b111;
            end
        end
    end

    // wait_cnt counts the stall cycles of the current access including the first,
    // so an access that never completes stalls exactly TIMEOUT cycles.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == IDLE) begin
            state_d    = memstall ? WAIT : IDLE;
            wait_cnt_d = memstall ? 16'd1 : 16'd0;
        end else if (state_q == WAIT) begin
            if (!memstall) begin
                state_d    = IDLE;
                wait_cnt_d = 16'd0;
            end else if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
                state_d = ERR;
            end else begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
        end
        mem_err_d   = mem_err_q | (state_d == ERR);
        stall_cnt_d = ((StallF | StallD | StallE | StallM) && !(&stall_cnt_q)) ?
                      stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
